// File: rtl/tm_qm_assoc_mem_mp_pkg.sv
// tm_qm_assoc_mem_mp_pkg: shared FSM states, CSR bit positions and helpers
package tm_qm_assoc_mem_mp_pkg;
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
  localparam int CSR_BUSY_BIT = 8;
  localparam int CSR_RESTART_BIT = 0;
  function automatic int rr_next(input int c, input int n);
    return (c + 1) % n;
  endfunction
endpackage

// File: rtl/tm_qm_bram_sp.sv
// tm_qm_bram_sp: inferred single-port write-first RAM with registered read
module tm_qm_bram_sp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // one access per cycle; a write returns its own data
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= we ? wdata : mem[addr];
  end
endmodule

// File: rtl/tm_qm_assoc_mem_mp.sv
// tm_qm_assoc_mem_mp: multi-channel association table with PIO, init walk and CSR
module tm_qm_assoc_mem_mp
  import tm_qm_assoc_mem_mp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int NUM_CH = 4,
  parameter int PIO_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reg_ms,
  input  logic                     reg_rd,
  input  logic                     reg_wr,
  input  logic [PIO_W-1:0]         reg_addr,
  input  logic [PIO_W-1:0]         reg_din,
  output logic                     mem_ack,
  output logic [PIO_W-1:0]         mem_rdata,
  input  logic [NUM_CH-1:0]        app_rd,
  input  logic [NUM_CH*ADDR_W-1:0] app_raddr,
  output logic [NUM_CH-1:0]        app_ack,
  output logic [NUM_CH*DATA_W-1:0] app_rdata,
  output logic                     init_busy
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  state_t state, state_n;
  logic [ADDR_W-1:0] init_cnt, addr, pio_a;
  logic [ADDR_W-1:0] app_a [NUM_CH];
  logic [DATA_W-1:0] pio_d, wdata, rdata;
  logic [NUM_CH-1:0] app_v, ovf, elig, gnt_vec;
  logic [CH_W-1:0] ptr, sel, s1_ch;
  logic [PIO_W-1:0] csr_val;
  logic pio_v, pio_wr, pio_csr, in_init, pio_req, pio_gnt, app_gnt, csr_go, restart, we, found;
  logic s1_app, s1_pio, unused_ok;
  assign unused_ok = ^{reg_addr, reg_din};
  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else state <= state_n;
  end
  // FSM next state: a restart wins over the end of the walk
  always_comb state_n = restart ? ST_INIT : (in_init && &init_cnt) ? ST_RUN : state;
  // FSM outputs
  always_comb begin
    in_init = state == ST_INIT;
    init_busy = in_init;
  end
  // round-robin search over channels that are pending and not being re-strobed
  always_comb begin
    elig = app_v & ~app_rd;
    found = 1'b0;
    sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      automatic int k = (int'(ptr) + i) % NUM_CH;
      if (!found && elig[k]) begin
        found = 1'b1;
        sel = CH_W'(k);
      end
    end
  end
  // port arbitration: init walk > PIO table access > app channels; CSR bypasses the RAM
  always_comb begin
    csr_go = pio_v & pio_csr;
    restart = csr_go & pio_wr & pio_d[CSR_RESTART_BIT];
    pio_req = pio_v & ~pio_csr;
    pio_gnt = ~in_init & pio_req;
    app_gnt = ~in_init & ~pio_req & found;
    gnt_vec = '0;
    gnt_vec[sel] = app_gnt;
    we = in_init | (pio_gnt & pio_wr);
    addr = in_init ? init_cnt : pio_gnt ? pio_a : app_a[sel];
    wdata = in_init ? '0 : pio_d;
    csr_val = '0;
    csr_val[CSR_BUSY_BIT] = in_init;
    csr_val[NUM_CH-1:0] = ovf;
  end
  tm_qm_bram_sp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bram (
    .clk(clk), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
  );
  // pending requests, init counter, overflow flags, read pipeline and completions
  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt <= '0;
      pio_v <= 1'b0;
      app_v <= '0;
      ovf <= '0;
      ptr <= '0;
      s1_app <= 1'b0;
      s1_pio <= 1'b0;
      mem_ack <= 1'b0;
      mem_rdata <= '0;
      app_ack <= '0;
      app_rdata <= '0;
    end else begin
      init_cnt <= restart ? '0 : in_init ? init_cnt + 1'b1 : init_cnt;
      if (pio_gnt || csr_go) pio_v <= 1'b0;
      else if (!pio_v && reg_ms && (reg_rd || reg_wr)) begin
        pio_v <= 1'b1;
        pio_wr <= reg_wr;
        pio_csr <= reg_addr[ADDR_W];
        pio_a <= reg_addr[ADDR_W-1:0];
        pio_d <= reg_din[DATA_W-1:0];
      end
      for (int c = 0; c < NUM_CH; c++)
        if (app_rd[c]) app_a[c] <= app_raddr[c*ADDR_W +: ADDR_W];
      app_v <= app_rd | (app_v & ~gnt_vec);
      ovf <= ((csr_go && pio_wr) ? '0 : ovf) | (app_rd & app_v);
      if (app_gnt) ptr <= CH_W'(rr_next(int'(sel), NUM_CH));
      s1_app <= app_gnt;
      s1_ch <= sel;
      s1_pio <= pio_gnt & ~pio_wr;
      mem_ack <= s1_pio | (pio_gnt & pio_wr) | csr_go;
      mem_rdata <= s1_pio ? PIO_W'(rdata) : (csr_go && !pio_wr) ? csr_val : mem_rdata;
      for (int c = 0; c < NUM_CH; c++) begin
        app_ack[c] <= s1_app && s1_ch == CH_W'(c);
        if (s1_app && s1_ch == CH_W'(c)) app_rdata[c*DATA_W +: DATA_W] <= rdata;
      end
    end
  end
endmodule

// File: tb/tb_tm_qm_assoc_mem_mp.sv
// tb_tm_qm_assoc_mem_mp: randomized self-checking bench against a table/RR model
module tb_tm_qm_assoc_mem_mp;
  localparam int NC = 4, DW = 16, AW = 10;
  logic clk = 0, rst = 1, reg_ms = 0, reg_rd = 0, reg_wr = 0;
  logic [31:0] reg_addr = 0, reg_din = 0;
  logic mem_ack, init_busy;
  logic [31:0] mem_rdata;
  logic [NC-1:0] app_rd = 0, app_ack;
  logic [NC*AW-1:0] app_raddr = 0;
  logic [NC*DW-1:0] app_rdata;
  int n_vec = 0, n_err = 0, cyc = 0, ptr = 0;
  int ack_cnt[NC] = '{default: 0};
  int ack_cyc[NC] = '{default: 0};
  logic [15:0] ack_dat[NC];
  int mem_cnt = 0, mem_cyc = 0;
  logic [31:0] mem_dat = 0;
  logic [15:0] mdl[1024];
  logic [9:0] wq[$];
  logic [9:0] a[4];

  tm_qm_assoc_mem_mp dut (
    .clk(clk), .rst(rst), .reg_ms(reg_ms), .reg_rd(reg_rd), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_din(reg_din), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .app_rd(app_rd), .app_raddr(app_raddr), .app_ack(app_ack), .app_rdata(app_rdata),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_ack) begin mem_cnt++; mem_cyc = cyc; mem_dat = mem_rdata; end
    for (int c = 0; c < NC; c++)
      if (app_ack[c]) begin ack_cnt[c]++; ack_cyc[c] = cyc; ack_dat[c] = app_rdata[c*DW +: DW]; end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (init_busy && n < 3000) begin n++; tick; end
  endtask

  task automatic pio(input bit wr, input logic [31:0] ad, input logic [31:0] d, output logic [31:0] q, output int lat);
    int base = mem_cnt;
    int s = cyc;
    reg_ms = 1; reg_rd = !wr; reg_wr = wr; reg_addr = ad; reg_din = d;
    tick;
    reg_ms = 0; reg_rd = 0; reg_wr = 0;
    for (int k = 0; k < 20 && mem_cnt == base; k++) tick;
    q = 0; lat = -1;
    if (mem_cnt == base) chk("pio_timeout", 0, 1);
    else begin lat = mem_cyc - s; q = mem_dat; end
  endtask

  task automatic pio_wr_mdl(input logic [9:0] ad, input logic [15:0] d);
    logic [31:0] q;
    int lat;
    pio(1, {22'b0, ad}, {16'b0, d}, q, lat);
    chk("pio_wr_lat", lat, 2);
    mdl[ad] = d;
  endtask

  task automatic burst(input logic [3:0] m, input logic [9:0] aa[4]);
    int base[4];
    int s, k, last;
    for (int c = 0; c < NC; c++) begin base[c] = ack_cnt[c]; app_raddr[c*AW +: AW] = aa[c]; end
    s = cyc; app_rd = m;
    tick;
    app_rd = '0;
    repeat (12) tick;
    k = 0; last = ptr;
    for (int i = 0; i < NC; i++) begin
      int ch;
      ch = (ptr + i) % NC;
      chk("burst_cnt", ack_cnt[ch] - base[ch], {31'b0, m[ch]});
      if (m[ch]) begin
        chk("burst_lat", ack_cyc[ch] - s, 3 + k);
        chk("burst_data", {16'b0, ack_dat[ch]}, {16'b0, mdl[aa[ch]]});
        k++; last = ch;
      end
    end
    ptr = (last + 1) % NC;
  endtask

  initial begin
    logic [31:0] q;
    int lat, n, s, b0, f;
    repeat (3) tick;
    chk("rst_mem_ack", {31'b0, mem_ack}, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_app_ack", {28'b0, app_ack}, 0);
    chk("rst_app_rdata", {31'b0, app_rdata != 0}, 0);
    chk("rst_busy", {31'b0, init_busy}, 1);
    rst = 0;
    wait_init(n);
    chk("init_len", n, 1024);
    foreach (mdl[i]) mdl[i] = 0;
    pio(0, 32'h3FF, 0, q, lat);
    chk("init_rd_3ff", q, 0);
    chk("pio_rd_lat", lat, 3);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < NC; c++) a[c] = 10'($urandom);
      burst(4'hF, a);
    end
    pio_wr_mdl(10'd5, 16'h00A5);
    for (int c = 0; c < NC; c++) a[c] = 10'($urandom);
    a[2] = 10'd5;
    burst(4'b0100, a);
    b0 = ack_cnt[1];
    app_rd = 4'b0010; app_raddr[AW +: AW] = 10'($urandom_range(6, 1023));
    tick;
    app_raddr[AW +: AW] = 10'd5;
    tick;
    app_rd = 0;
    repeat (10) tick;
    chk("ovf_ack_cnt", ack_cnt[1] - b0, 1);
    chk("ovf_data", {16'b0, ack_dat[1]}, 32'h00A5);
    ptr = 2;
    pio(0, 32'h400, 0, q, lat);
    chk("csr_ovf", q, 32'h002);
    chk("csr_lat", lat, 2);
    pio(1, 32'h400, 0, q, lat);
    chk("csr_wr_lat", lat, 2);
    pio(0, 32'h400, 0, q, lat);
    chk("csr_clr", q, 0);
    pio_wr_mdl(10'd9, 16'($urandom));
    b0 = ack_cnt[0]; n = mem_cnt; s = cyc;
    reg_ms = 1; reg_rd = 1; reg_addr = 9; app_rd = 4'b0001; app_raddr[0 +: AW] = 10'd5;
    tick;
    reg_ms = 0; reg_rd = 0; app_rd = 0;
    repeat (8) tick;
    chk("arb_pio_cnt", mem_cnt - n, 1);
    chk("arb_pio_lat", mem_cyc - s, 3);
    chk("arb_pio_data", mem_dat, {16'b0, mdl[9]});
    chk("arb_ch0_cnt", ack_cnt[0] - b0, 1);
    chk("arb_ch0_lat", ack_cyc[0] - s, 4);
    chk("arb_ch0_data", {16'b0, ack_dat[0]}, 32'h00A5);
    ptr = 1;
    for (int r = 0; r < 15; r++) begin
      repeat ($urandom_range(1, 3)) begin
        logic [9:0] wa;
        wa = 10'($urandom);
        pio_wr_mdl(wa, 16'($urandom));
        wq.push_back(wa);
      end
      for (int c = 0; c < NC; c++)
        a[c] = $urandom_range(0, 1) ? wq[$urandom_range(0, wq.size() - 1)] : 10'($urandom);
      burst(4'($urandom_range(1, 15)), a);
    end
    pio_wr_mdl(10'd1000, 16'hBEEF);
    pio(1, 32'h400, 1, q, lat);
    chk("restart_busy", {31'b0, init_busy}, 1);
    b0 = ack_cnt[3];
    app_rd = 4'b1000; app_raddr[3*AW +: AW] = 10'd1000;
    tick;
    app_rd = 0;
    wait_init(n);
    f = cyc;
    chk("restart_len", n + 1, 1024);
    repeat (6) tick;
    chk("init_pend_cnt", ack_cnt[3] - b0, 1);
    chk("init_pend_lat", ack_cyc[3] - f, 2);
    chk("init_pend_data", {16'b0, ack_dat[3]}, 0);
    ptr = 0;
    foreach (mdl[i]) mdl[i] = 0;
    for (int i = 0; i < wq.size(); i += 4) begin
      pio(0, {22'b0, wq[i]}, 0, q, lat);
      chk("restart_zero", q, 0);
    end
    pio_wr_mdl(10'd1000, 16'h1234);
    pio_wr_mdl(10'd2, 16'h0055);
    pio(1, 32'h400, 1, q, lat);
    repeat (500) tick;
    rst = 1;
    repeat (2) tick;
    chk("rst_mid_busy", {31'b0, init_busy}, 1);
    chk("rst_mid_ack", {31'b0, mem_ack}, 0);
    rst = 0;
    wait_init(n);
    chk("rst_walk_len", n, 1024);
    mdl[1000] = 0; mdl[2] = 0;
    pio(0, 32'd1000, 0, q, lat);
    chk("rst_walk_1000", q, 0);
    pio(0, 32'd2, 0, q, lat);
    chk("rst_walk_2", q, 0);
    pio(0, 32'h400, 0, q, lat);
    chk("rst_csr", q, 0);
    ptr = 0;
    for (int c = 0; c < NC; c++) a[c] = 10'($urandom);
    burst(4'hF, a);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tm_qm_assoc_mem_mp.md
# tm_qm_assoc_mem_mp

Parametrised, multi-channel successor to the first-level queue-association memory in the traffic manager queue manager. Holds a DEPTH x DATA_W association table in one single-port BRAM. NUM_CH independent application read channels and the PIO slave share that port through a fixed-priority plus round-robin arbiter. Adds hardware zero-initialisation after reset, a small CSR space and per-channel request-overflow detection.

## Interface
- DATA_W, 16, association entry width (1..32)
- ADDR_W, 10, table address width; DEPTH = 2^ADDR_W
- NUM_CH, 4, application read channels (1..8)
- PIO_W, 32, PIO address/data width (`PIO_RANGE`)
- clk  in  1  single clock; all logic on rising edge
- `RESET_SIG`  in  1  reset port per codebase macro; synchronous, active-high
- reg_ms  in  1  PIO module select; qualifies reg_rd/reg_wr
- reg_rd  in  1  PIO read strobe, one-cycle pulse
- reg_wr  in  1  PIO write strobe, one-cycle pulse
- reg_addr  in  PIO_W  bit ADDR_W = 1 selects CSR, else table word reg_addr[ADDR_W-1:0]
- reg_din  in  PIO_W  PIO write data; table uses [DATA_W-1:0]
- mem_ack  out  1  PIO completion pulse
- mem_rdata  out  PIO_W  PIO read data, zero-extended; valid with mem_ack
- app_rd  in  NUM_CH  per-channel read request pulse
- app_raddr  in  NUM_CH*ADDR_W  channel c address at [c*ADDR_W +: ADDR_W]
- app_ack  out  NUM_CH  per-channel read completion pulse
- app_rdata  out  NUM_CH*DATA_W  channel c data; held until that channel's next ack
- init_busy  out  1  table initialisation in progress

## Operation
- Each PIO request and each channel request is latched into its own pending register (valid + address/data) at the edge where its strobe is sampled.
- One BRAM access per cycle. Grant priority: init FSM > PIO pending > app pending (round-robin).
- Round-robin pointer starts at channel 0 after reset. After an app grant to channel c, search starts at c+1 mod NUM_CH.
- FSM states:
  - INIT: write zero to address init_cnt, then increment init_cnt. After address DEPTH-1 is written, go to RUN. init_busy = 1 throughout INIT.
  - RUN: normal arbitration.
- Requests arriving during INIT are latched and stay pending until RUN.
- Overflow: app_rd[c] while channel c is already pending sets sticky ovf[c]. The new address replaces the pending one, and exactly one ack is produced.
- PIO strobes while PIO is pending are ignored (PIO is single-outstanding by protocol).
- CSR read returns {init_busy at bit 8, ovf[NUM_CH-1:0] at bits 7:0}, zero elsewhere.
- CSR write: clears all ovf bits. If reg_din[0] = 1, it also restarts INIT with init_cnt = 0.
  - Pending app requests are kept across the restart.
  - A CSR access does not use the BRAM, so it never blocks app grants.
- Reset: clears all pending registers, ovf, init_cnt and the RR pointer, and sets state INIT. Reset mid-access drops every in-flight ack.

## Timing
- Reset values: mem_ack = 0, mem_rdata = 0, app_ack = 0, app_rdata = 0, init_busy = 1.
- INIT walk starts in the first cycle after reset deasserts and lasts DEPTH cycles. init_busy falls the cycle after the last write.
- BRAM read latency is 1 cycle (synchronous read).
- App request with strobe in cycle 0, granted in cycle 1: app_ack[c] and app_rdata in cycle 3. Minimum request-to-ack latency is 3 cycles.
- PIO table read/write: strobe in cycle 0, grant cycle 1. mem_ack in cycle 3 for reads and cycle 2 for writes.
- PIO CSR access: mem_ack in cycle 2.
- A write granted in cycle T is visible to any read granted in cycle T+1 or later.
- An app_rd that arrives in the same cycle as the ack of that channel's previous request is a new request, not an overflow.
- Worst-case app wait with all channels busy and no PIO: NUM_CH grant cycles.

## Structure
- Shared defines in `defines.vh`: FSM state encodings (INIT, RUN), CSR bit positions (init_busy bit 8, ovf bits 7:0, restart bit 0), CSR select bit position.
- Sub-module `tm_qm_bram_sp`: inferred single-port RAM, parameters DATA_W/ADDR_W, write-first, 1-cycle registered read.
- Arbiter, init FSM, pending registers and CSR logic live in the top module.

## Test plan
- Reset then idle → init_busy = 1 for exactly 1024 cycles. A PIO read of address 0x3FF then returns 0 with mem_ack 3 cycles after the strobe.
- PIO write 0x00A5 to address 5, then ch2 reads address 5 → app_ack[2] with app_rdata = 0x00A5, and no ack on other channels.
- All 4 channels strobe in the same cycle with distinct addresses → grants and acks in order ch0, ch1, ch2, ch3, one per cycle. A later simultaneous burst starts at ch0 again (pointer = 3+1 mod 4).
- ch1 strobes twice on consecutive cycles → a single ack for the second address, and a CSR read returns ovf = 0x02. A CSR write with data 0 then reads back 0x000.
- PIO read and ch0 read in the same cycle → PIO granted first. ch0 ack arrives one cycle later than its minimum latency.
- CSR write with reg_din = 1 after table writes → init_busy reasserts, and afterwards every written address reads 0. Reset asserted mid-INIT → the walk restarts from address 0.
